// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared widths and requester indices for the writeback port arbiter
//
// Purpose: common constants for the writeback path between the execute/memory
//          units and the int/fp register files.
// Contents: DATA_WIDTH, REG_ADDR_WIDTH, WB_NREQ, requester index constants.
package wb_port_arbiter_pkg;

  localparam int DATA_WIDTH     = 64;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int WB_NREQ        = 3;

  // Requester slots on the arbiter input vectors.
  localparam int WB_INT = 0;
  localparam int WB_FPU = 1;
  localparam int WB_LSU = 2;

endpackage

// File: rtl/wb_port_arbiter_picker.sv
// rtl/wb_port_arbiter_picker.sv - combinational round-robin priority picker
//
// Purpose: picks the first valid requester scanning ptr, ptr+1, ... mod NReq.
// Ports:
//   valid_i  in  NReq  request vector
//   ptr_i    in  IdxW  highest-priority slot this cycle
//   grant_o  out NReq  one-hot grant (all zero when nothing valid)
//   idx_o    out IdxW  binary index of the granted slot
//   any_o    out 1     at least one request valid
module rr_priority_picker #(
  parameter int NReq = 3,
  parameter int IdxW = 2
) (
  input  logic [NReq-1:0] valid_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [NReq-1:0] grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  int              pos;
  logic [IdxW-1:0] slot;

  // Scan offsets from farthest to nearest so the slot closest to ptr is the
  // last one written and therefore wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    slot    = '0;
    for (int k = NReq - 1; k >= 0; k--) begin
      pos = int'(ptr_i) + k;
      if (pos >= NReq) pos = pos - NReq;
      slot = IdxW'(pos);
      if (valid_i[slot]) begin
        grant_o       = '0;
        grant_o[slot] = 1'b1;
        idx_o         = slot;
        any_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter_reg.sv
// rtl/wb_port_arbiter_reg.sv - load-enabled register with synchronous active-high clear
//
// Purpose: generic storage element used for every flop in the arbiter.
// Ports:
//   clk_i   in  1  clock
//   reset_i in  1  synchronous active-high clear, overrides load
//   load_i  in  1  capture d_i when high
//   d_i     in  W  next value
//   q_o     out W  stored value
module wb_port_arbiter_reg #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_o <= '0;
    end else if (load_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin arbiter for the shared register-file write port
//
// Purpose: grants one writeback producer per cycle (int pipe, FPU, load unit),
//          captures the winner into an output stage driving the register file
//          one cycle later.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_valid_i/req_ready_o  per-requester handshake, ready is one-hot
//   req_fp_i/addr_i/data_i   per-requester write target and payload
//   wr_load_o/fp_o/addr_o/data_o  register-file write port
//   grant_id_o               requester held in the output stage
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NReq      = WB_NREQ,
  parameter int DataWidth = DATA_WIDTH,
  parameter int AddrWidth = REG_ADDR_WIDTH,
  localparam int IdxW     = $clog2(NReq)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NReq-1:0]           req_valid_i,
  output logic [NReq-1:0]           req_ready_o,
  input  logic [NReq-1:0]           req_fp_i,
  input  logic [NReq*AddrWidth-1:0] req_addr_i,
  input  logic [NReq*DataWidth-1:0] req_data_i,
  output logic                      wr_load_o,
  output logic                      wr_fp_o,
  output logic [AddrWidth-1:0]      wr_addr_o,
  output logic [DataWidth-1:0]      wr_data_o,
  output logic [IdxW-1:0]           grant_id_o
);

  logic [NReq-1:0]      grant;
  logic [IdxW-1:0]      g_idx;
  logic                 any_valid;
  logic                 hs;
  logic                 sel_fp;
  logic [AddrWidth-1:0] sel_addr;
  logic [DataWidth-1:0] sel_data;

  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic                 load_q, load_d;
  logic                 fp_q, fp_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [IdxW-1:0]      gid_q, gid_d;

  rr_priority_picker #(
    .NReq (NReq),
    .IdxW (IdxW)
  ) u_picker (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (g_idx),
    .any_o   (any_valid)
  );

  // Reset masks ready so a requester never sees a handshake that the
  // registers are about to discard.
  assign req_ready_o = reset ? '0 : grant;
  assign hs          = any_valid & ~reset;

  assign sel_fp   = req_fp_i[g_idx];
  assign sel_addr = req_addr_i[g_idx*AddrWidth +: AddrWidth];
  assign sel_data = req_data_i[g_idx*DataWidth +: DataWidth];

  always_comb begin
    ptr_d  = ptr_q;
    load_d = 1'b0;
    fp_d   = fp_q;
    addr_d = addr_q;
    data_d = data_q;
    gid_d  = gid_q;
    if (hs) begin
      ptr_d  = (g_idx == IdxW'(NReq - 1)) ? '0 : g_idx + 1'b1;
      // Integer x0 is hardwired zero: accept the request but suppress the write.
      load_d = sel_fp | (sel_addr != '0);
      fp_d   = sel_fp;
      addr_d = sel_addr;
      data_d = sel_data;
      gid_d  = g_idx;
    end
  end

  wb_port_arbiter_reg #(.W(IdxW)) u_ptr (
    .clk_i(clk), .reset_i(reset), .load_i(1'b1), .d_i(ptr_d), .q_o(ptr_q));
  wb_port_arbiter_reg #(.W(1)) u_load (
    .clk_i(clk), .reset_i(reset), .load_i(1'b1), .d_i(load_d), .q_o(load_q));
  wb_port_arbiter_reg #(.W(1)) u_fp (
    .clk_i(clk), .reset_i(reset), .load_i(1'b1), .d_i(fp_d), .q_o(fp_q));
  wb_port_arbiter_reg #(.W(AddrWidth)) u_addr (
    .clk_i(clk), .reset_i(reset), .load_i(1'b1), .d_i(addr_d), .q_o(addr_q));
  wb_port_arbiter_reg #(.W(DataWidth)) u_data (
    .clk_i(clk), .reset_i(reset), .load_i(1'b1), .d_i(data_d), .q_o(data_q));
  wb_port_arbiter_reg #(.W(IdxW)) u_gid (
    .clk_i(clk), .reset_i(reset), .load_i(1'b1), .d_i(gid_d), .q_o(gid_q));

  assign wr_load_o  = load_q;
  assign wr_fp_o    = fp_q;
  assign wr_addr_o  = addr_q;
  assign wr_data_o  = data_q;
  assign grant_id_o = gid_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;
  localparam int N  = 3;
  localparam int DW = 64;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [N-1:0]    req_fp_i = '0;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic            wr_load_o;
  logic            wr_fp_o;
  logic [AW-1:0]   wr_addr_o;
  logic [DW-1:0]   wr_data_o;
  logic [1:0]      grant_id_o;

  wb_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_fp_i(req_fp_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .wr_load_o(wr_load_o), .wr_fp_o(wr_fp_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .grant_id_o(grant_id_o)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntotal = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: priority pointer, expected output stage, pending writes.
  typedef struct {
    logic          fp;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            id;
  } wr_t;

  int        m_ptr = 0;
  int        m_g = -1;
  logic      m_load = 0;
  wr_t       m_stage = '{fp: 0, addr: 0, data: 0, id: 0};
  wr_t       sb[$];
  int        wait_cnt[N] = '{default: 0};

  task automatic do_cycle(input logic rst, input logic [N-1:0] v, input logic [N-1:0] fp,
                          input logic [N*AW-1:0] ad, input logic [N*DW-1:0] dt);
    logic [N-1:0] exp_rdy;
    wr_t w;
    reset = rst; req_valid_i = v; req_fp_i = fp; req_addr_i = ad; req_data_i = dt;
    @(negedge clk);
    m_g = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        int s;
        s = (m_ptr + k) % N;
        if (m_g < 0 && v[s]) m_g = s;
      end
    end
    exp_rdy = '0;
    if (m_g >= 0) exp_rdy[m_g] = 1'b1;
    chk("ready", DW'(req_ready_o), DW'(exp_rdy));
    chk("onehot0", DW'($onehot0(req_ready_o)), 64'd1);
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_load = 0; m_stage = '{fp: 0, addr: 0, data: 0, id: 0};
      sb.delete();
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i == m_g) begin
          chk("fairness", DW'(wait_cnt[i] < N), 64'd1);
          wait_cnt[i] = 0;
        end else if (v[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
      end
      if (m_g >= 0) begin
        w.fp = fp[m_g]; w.addr = ad[m_g*AW +: AW]; w.data = dt[m_g*DW +: DW]; w.id = m_g;
        m_stage = w;
        m_load = w.fp || (w.addr != 0);
        if (m_load) sb.push_back(w);
        m_ptr = (m_g + 1) % N;
      end else m_load = 0;
    end
    #1;
    chk("wr_load", DW'(wr_load_o), DW'(m_load));
    chk("wr_fp", DW'(wr_fp_o), DW'(m_stage.fp));
    chk("wr_addr", DW'(wr_addr_o), DW'(m_stage.addr));
    chk("wr_data", wr_data_o, m_stage.data);
    chk("grant_id", DW'(grant_id_o), DW'(m_stage.id));
    if (wr_load_o) begin
      if (sb.size() == 0) chk("sb_unexpected_write", 64'd1, 64'd0);
      else begin
        w = sb.pop_front();
        chk("sb_order", {wr_fp_o, wr_addr_o, DW'(grant_id_o)}, {w.fp, w.addr, DW'(w.id)});
        chk("sb_data", wr_data_o, w.data);
      end
    end
  endtask

  typedef struct {
    logic          rst;
    logic [N-1:0]  valid;
    logic [N-1:0]  fp;
    logic [N*AW-1:0] addr;
    logic [N-1:0]  exp_ready;
    logic          exp_load;
    logic [1:0]    exp_gid;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [N*AW-1:0] a_std, a_x0;
    logic [N*DW-1:0] dt;
    logic [N-1:0]    pv, pfp;
    logic [N*AW-1:0] pad;
    logic [N*DW-1:0] pdt;
    logic            rr;

    a_std = {5'd9, 5'd7, 5'd3};
    a_x0  = {5'd0, 5'd7, 5'd3};
    //          rst  valid   fp      addr   ready   load gid
    tbl[0]  = '{1'b1, 3'b111, 3'b000, a_std, 3'b000, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 3'b111, 3'b000, a_std, 3'b000, 1'b0, 2'd0};
    tbl[2]  = '{1'b0, 3'b111, 3'b000, a_std, 3'b001, 1'b1, 2'd0};
    tbl[3]  = '{1'b0, 3'b010, 3'b000, a_std, 3'b010, 1'b1, 2'd1};
    tbl[4]  = '{1'b0, 3'b100, 3'b000, a_std, 3'b100, 1'b1, 2'd2};
    tbl[5]  = '{1'b0, 3'b000, 3'b000, a_std, 3'b000, 1'b0, 2'd2};
    tbl[6]  = '{1'b0, 3'b111, 3'b000, a_std, 3'b001, 1'b1, 2'd0};
    tbl[7]  = '{1'b0, 3'b111, 3'b000, a_std, 3'b010, 1'b1, 2'd1};
    tbl[8]  = '{1'b0, 3'b111, 3'b000, a_std, 3'b100, 1'b1, 2'd2};
    tbl[9]  = '{1'b0, 3'b111, 3'b000, a_std, 3'b001, 1'b1, 2'd0};
    tbl[10] = '{1'b0, 3'b111, 3'b000, a_std, 3'b010, 1'b1, 2'd1};
    tbl[11] = '{1'b0, 3'b111, 3'b000, a_std, 3'b100, 1'b1, 2'd2};
    tbl[12] = '{1'b0, 3'b100, 3'b000, a_x0,  3'b100, 1'b0, 2'd2};
    tbl[13] = '{1'b0, 3'b100, 3'b100, a_x0,  3'b100, 1'b1, 2'd2};
    tbl[14] = '{1'b0, 3'b010, 3'b000, a_std, 3'b010, 1'b1, 2'd1};
    tbl[15] = '{1'b0, 3'b011, 3'b000, a_std, 3'b001, 1'b1, 2'd0};
    tbl[16] = '{1'b0, 3'b010, 3'b000, a_std, 3'b010, 1'b1, 2'd1};
    tbl[17] = '{1'b1, 3'b001, 3'b000, a_std, 3'b000, 1'b0, 2'd0};
    tbl[18] = '{1'b0, 3'b001, 3'b000, a_std, 3'b001, 1'b1, 2'd0};
    tbl[19] = '{1'b0, 3'b000, 3'b000, a_std, 3'b000, 1'b0, 2'd0};

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++)
        dt[i*DW +: DW] = (i == 1) ? 64'hDEAD_BEEF : 64'(k * 16 + i);
      do_cycle(tbl[k].rst, tbl[k].valid, tbl[k].fp, tbl[k].addr, dt);
      chk($sformatf("tbl%0d_load", k), DW'(wr_load_o), DW'(tbl[k].exp_load));
      chk($sformatf("tbl%0d_gid", k), DW'(grant_id_o), DW'(tbl[k].exp_gid));
      if (k == 3) begin
        chk("tbl3_addr", DW'(wr_addr_o), 64'd7);
        chk("tbl3_data", wr_data_o, 64'hDEAD_BEEF);
      end
      if (k == 13) chk("tbl13_fp", DW'(wr_fp_o), 64'd1);
      if (k == 1) begin
        chk("rst_addr", DW'(wr_addr_o), 64'd0);
        chk("rst_data", wr_data_o, 64'd0);
      end
    end

    // Randomized traffic; requesters hold their payload until granted.
    pv = '0; pfp = '0; pad = '0; pdt = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && ($urandom % 3 != 0)) begin
          pv[i] = 1'b1;
          pfp[i] = 1'($urandom);
          pad[i*AW +: AW] = ($urandom % 4 == 0) ? 5'd0 : AW'($urandom);
          pdt[i*DW +: DW] = {$urandom, $urandom};
        end
      end
      rr = ($urandom % 40 == 0);
      do_cycle(rr, pv, pfp, pad, pdt);
      if (m_g >= 0) pv[m_g] = 1'b0;
    end

    do_cycle(1'b0, '0, '0, '0, '0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
